led_fx_driver: RTL and testbench
================================

LED_FX_DRIVER -- requirements
Module: led_fx_driver

Interface
REQ-001 The block SHALL have parameter FXBaseAddr, default 8'hC2, the first of four bus-mapped registers, C2..C5.
REQ-002 The block SHALL have parameter PRESCALE, default 100000, the number of CLK cycles per blink tick; it SHALL be at least 2.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port BUS_DATA, input, 8 bits: CPU write data.
REQ-006 The block SHALL have port BUS_ADDR, input, 8 bits: CPU address.
REQ-007 The block SHALL have port BUS_WE, input, 1 bit: CPU write enable.
REQ-008 The block SHALL have port LED_IN, input, 16 bits: {LEDH, LEDL} from the LED register peripheral at C0/C1.
REQ-009 The block SHALL have port LED_OUT, output, 16 bits, registered: drive to the physical LEDs.

Function
REQ-010 The block SHALL decode the following registers, each written when BUS_WE=1 and BUS_ADDR matches:
- BRIGHT_NEXT at FXBaseAddr+0.
- MASKL at +1, covering LED_OUT[7:0].
- MASKH at +2, covering LED_OUT[15:8].
- CTRL at +3: bit0 PWM_EN, bit1 BLINK_EN, bits[3:2] RATE, bits[7:4] ignored.
REQ-011 Writes to addresses outside FXBaseAddr..FXBaseAddr+3 SHALL be ignored. The block SHALL never drive BUS_DATA.
REQ-012 Register writes SHALL take effect on the CLK edge on which BUS_WE is sampled high.
REQ-013 PWM counter pwm_cnt (8 bits) SHALL increment every cycle, wrapping 255->0.
REQ-014 BRIGHT_NEXT SHALL copy into the active duty register BRIGHT only on the cycle pwm_cnt wraps 255->0, so no partial PWM period occurs.
REQ-015 pwm_gate SHALL be:
- 1 if PWM_EN=0.
- 1 if BRIGHT=8'hFF.
- Otherwise (pwm_cnt < BRIGHT); BRIGHT=0 therefore gives constant 0.
REQ-016 The prescaler SHALL count 0..PRESCALE-1 and wrap. It SHALL emit a one-cycle tick on the wrap cycle.
REQ-017 The 4-bit blink counter blink_cnt SHALL increment on each tick, wrapping 15->0.
REQ-018 phase SHALL equal blink_cnt[RATE]; RATE=0 is the fastest rate and RATE=3 the slowest. phase=0 means the LED is lit and phase=1 means it is dark.
REQ-019 Any write to CTRL SHALL clear the prescaler and blink_cnt to 0 on the same edge, so the blink period restarts in the lit phase.
REQ-020 On every cycle, LED_OUT[i] SHALL be loaded with LED_IN[i] AND pwm_gate AND NOT(BLINK_EN AND MASK[i] AND phase), where MASK = {MASKH, MASKL}.
REQ-021 Latency from LED_IN, pwm_cnt or phase to LED_OUT SHALL be exactly 1 cycle; there SHALL be no combinational path from input to output.
REQ-022 A write to CTRL on the same edge as a tick SHALL take priority: the counters clear and do not increment.
REQ-023 A write to BRIGHT_NEXT on the pwm wrap edge SHALL NOT be taken that edge; the old BRIGHT_NEXT is transferred, and the new value takes effect at the next wrap.

Reset
REQ-024 While RESET=1, independent of CLK, the block SHALL hold:
- LED_OUT = 16'h0000.
- pwm_cnt, prescaler and blink_cnt = 0.
- BRIGHT = BRIGHT_NEXT = 8'hFF.
- MASKL = MASKH = 8'h00.
- CTRL = 8'h00, giving pure passthrough with 1-cycle delay.
REQ-025 Reset asserted mid-PWM-period or mid-blink SHALL abort immediately to the REQ-024 values. The first non-reset edge SHALL load LED_OUT from LED_IN under the reset register values.

Verification
REQ-026 The bench SHALL cover passthrough: after reset, LED_IN=16'h00F0 -> LED_OUT=16'h00F0 one cycle later, and unchanged while registers keep their reset values.
REQ-027 The bench SHALL cover PWM duty: write C5=8'h01 and C2=8'h40; LED_IN=16'hFFFF -> from the first wrap after the write, LED_OUT=16'hFFFF for exactly 64 of every 256 cycles; write C2=8'h00 -> LED_OUT held at 0 from the next wrap.
REQ-028 The bench SHALL cover deferred duty: write C2=8'h80 at pwm_cnt=100 -> the duty stays at its old value until pwm_cnt wraps; write C2 exactly on the wrap edge -> the new duty applies one period later.
REQ-029 The bench SHALL cover blink with PRESCALE=4: write C3=8'h0F, C4=8'h00 and C5=8'h02 (RATE=0) -> LED_OUT[3:0] toggles every 4 cycles starting lit, and LED_OUT[15:4] follows LED_IN steadily; RATE=2 -> toggles every 16 cycles.
REQ-030 The bench SHALL cover CTRL-write collision: write C5 on a tick cycle -> blink_cnt=0 and the prescaler=0 on the next cycle, with the lit phase.
REQ-031 The bench SHALL cover asynchronous reset: assert RESET between CLK edges during an active blink-dark phase -> LED_OUT=0 before the next edge and all registers at their REQ-024 values; on release, passthrough resumes.
REQ-032 The bench SHALL cover address decode: writes to C0, C1 and C6 -> no change to any led_fx_driver register.

Source files
------------

// File: rtl/led_fx_driver.sv
// LED effects stage: PWM dimming and masked blinking applied to the LED register image.
// Latency: LED_IN / pwm_cnt / blink phase to LED_OUT is exactly one CLK cycle (output registered).
// Backpressure: none; bus writes are single-cycle and always accepted, LED_OUT updates every cycle.
//
// Ports:
//   CLK       - system clock, all state on rising edge
//   RESET     - asynchronous active-high reset
//   BUS_DATA  - CPU write data (input only, never driven)
//   BUS_ADDR  - CPU address; registers at FXBaseAddr+0..+3
//   BUS_WE    - CPU write enable
//   LED_IN    - {LEDH, LEDL} from the LED register peripheral
//   LED_OUT   - registered drive to the physical LEDs
//
// Register map (offset from FXBaseAddr):
//   +0 BRIGHT_NEXT  duty staged here, copied to the active duty at PWM wrap
//   +1 MASKL        blink mask for LED_OUT[7:0]
//   +2 MASKH        blink mask for LED_OUT[15:8]
//   +3 CTRL         bit0 PWM_EN, bit1 BLINK_EN, bits[3:2] RATE
module led_fx_driver #(
   parameter logic [7:0] FXBaseAddr = 8'hC2,
   parameter int         PRESCALE   = 100000   // CLK cycles per blink tick, must be >= 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  BUS_DATA,
   input  logic [7:0]  BUS_ADDR,
   input  logic        BUS_WE,
   input  logic [15:0] LED_IN,
   output logic [15:0] LED_OUT
);

   localparam int               PW          = $clog2(PRESCALE);
   localparam logic [PW-1:0]    PRESC_LAST  = PW'(PRESCALE - 1);
   localparam logic [7:0]       ADDR_BRIGHT = FXBaseAddr;
   localparam logic [7:0]       ADDR_MASKL  = FXBaseAddr + 8'd1;
   localparam logic [7:0]       ADDR_MASKH  = FXBaseAddr + 8'd2;
   localparam logic [7:0]       ADDR_CTRL   = FXBaseAddr + 8'd3;

   logic [7:0]    r_pwm_cnt;
   logic [7:0]    r_bright;
   logic [7:0]    r_bright_next;
   logic [7:0]    r_maskl;
   logic [7:0]    r_maskh;
   logic [3:0]    r_ctrl;
   logic [PW-1:0] r_presc;
   logic [3:0]    r_blink_cnt;

   logic          w_wr_bright;
   logic          w_wr_maskl;
   logic          w_wr_maskh;
   logic          w_wr_ctrl;
   logic          w_pwm_wrap;
   logic          w_pwm_gate;
   logic          w_tick;
   logic          w_phase;
   logic          w_blank;
   logic [15:0]   w_mask;

   // Bus decode
   assign w_wr_bright = BUS_WE && (BUS_ADDR == ADDR_BRIGHT);
   assign w_wr_maskl  = BUS_WE && (BUS_ADDR == ADDR_MASKL);
   assign w_wr_maskh  = BUS_WE && (BUS_ADDR == ADDR_MASKH);
   assign w_wr_ctrl   = BUS_WE && (BUS_ADDR == ADDR_CTRL);

   // PWM: the active duty only changes at the 255->0 wrap so a period is never cut short.
   // A BRIGHT_NEXT write landing on the wrap edge is naturally deferred: the copy
   // samples the old staged value while the new one lands in BRIGHT_NEXT.
   assign w_pwm_wrap = (r_pwm_cnt == 8'hFF);
   assign w_pwm_gate = !r_ctrl[0] || (r_bright == 8'hFF) || (r_pwm_cnt < r_bright);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_pwm_cnt     <= 8'h00;
         r_bright      <= 8'hFF;
         r_bright_next <= 8'hFF;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 8'd1;
         if (w_pwm_wrap)
            r_bright <= r_bright_next;
         if (w_wr_bright)
            r_bright_next <= BUS_DATA;
      end
   end

   // Mask and control registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_maskl <= 8'h00;
         r_maskh <= 8'h00;
         r_ctrl  <= 4'h0;
      end else begin
         if (w_wr_maskl)
            r_maskl <= BUS_DATA;
         if (w_wr_maskh)
            r_maskh <= BUS_DATA;
         if (w_wr_ctrl)
            r_ctrl <= BUS_DATA[3:0];
      end
   end

   // Blink timebase. A CTRL write restarts the blink period in the lit phase and
   // wins over a coincident tick.
   assign w_tick = (r_presc == PRESC_LAST);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_presc     <= '0;
         r_blink_cnt <= 4'h0;
      end else if (w_wr_ctrl) begin
         r_presc     <= '0;
         r_blink_cnt <= 4'h0;
      end else if (w_tick) begin
         r_presc     <= '0;
         r_blink_cnt <= r_blink_cnt + 4'd1;
      end else begin
         r_presc     <= r_presc + PW'(1);
      end
   end

   // RATE selects which blink counter bit drives the phase; higher bit = slower blink.
   assign w_phase = r_blink_cnt[r_ctrl[3:2]];
   assign w_blank = r_ctrl[1] && w_phase;
   assign w_mask  = {r_maskh, r_maskl};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         LED_OUT <= 16'h0000;
      else
         LED_OUT <= LED_IN & {16{w_pwm_gate}} & ~(w_mask & {16{w_blank}});
   end

endmodule

// File: tb/tb_led_fx_driver.sv
// Directed bench for led_fx_driver with PRESCALE=4.
// Inputs change 1 ns after the rising edge; LED_OUT is sampled at the same point.
// m_pwm tracks the DUT PWM counter value after each edge since reset release.
module tb_led_fx_driver;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  BUS_DATA;
   logic [7:0]  BUS_ADDR;
   logic        BUS_WE;
   logic [15:0] LED_IN;
   logic [15:0] LED_OUT;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  m_pwm;

   always #5 CLK = ~CLK;

   led_fx_driver #(
      .FXBaseAddr (8'hC2),
      .PRESCALE   (4)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .BUS_DATA (BUS_DATA),
      .BUS_ADDR (BUS_ADDR),
      .BUS_WE   (BUS_WE),
      .LED_IN   (LED_IN),
      .LED_OUT  (LED_OUT)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
      m_pwm = m_pwm + 8'd1;
   endtask

   task automatic chk(input string tag, input logic [15:0] exp);
      checks++;
      assert (LED_OUT === exp)
      else begin
         errors++;
         $error("FAIL %s: LED_OUT observed %h expected %h", tag, LED_OUT, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      BUS_ADDR = a;
      BUS_DATA = d;
      BUS_WE   = 1'b1;
      tick();
      BUS_WE   = 1'b0;
      BUS_ADDR = 8'h00;
      BUS_DATA = 8'h00;
   endtask

   // Advance without checking until the PWM counter reaches target (at least one edge).
   task automatic advance_to(input logic [7:0] target);
      do tick(); while (m_pwm != target);
   endtask

   // LED_OUT after an edge is lit iff the pwm count before that edge was below duty.
   task automatic run_to(input string tag, input logic [7:0] target, input logic [7:0] duty);
      logic [7:0] prev;
      do begin
         prev = m_pwm;
         tick();
         chk(tag, (prev < duty) ? LED_IN : 16'h0000);
      end while (m_pwm != target);
   endtask

   // Edge k after a CTRL write sees the phase from floor((k-1)/half) parity.
   task automatic blink_check(input string tag, input int n, input int half,
                              input logic [15:0] lit, input logic [15:0] dark);
      for (int k = 1; k <= n; k++) begin
         tick();
         chk(tag, ((((k - 1) / half) % 2) == 1) ? dark : lit);
      end
   endtask

   initial begin
      RESET    = 1'b1;
      BUS_DATA = 8'h00;
      BUS_ADDR = 8'h00;
      BUS_WE   = 1'b0;
      LED_IN   = 16'hFFFF;
      m_pwm    = 8'h00;

      // Reset state
      @(posedge CLK); #1;
      chk("reset_led_out", 16'h0000);
      @(posedge CLK); #1;
      chk("reset_hold", 16'h0000);

      // Passthrough from the first non-reset edge
      LED_IN = 16'h00F0;
      #3 RESET = 1'b0;
      m_pwm = 8'h00;
      tick();
      chk("pass_first_edge", 16'h00F0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("pass_steady", 16'h00F0);
      end
      LED_IN = 16'h1234;
      #1 chk("pass_no_comb", 16'h00F0);
      tick();
      chk("pass_latency", 16'h1234);

      // PWM duty 0x40, then duty 0 from the following wrap
      LED_IN = 16'hFFFF;
      wr(8'hC5, 8'h01);
      wr(8'hC2, 8'h40);
      advance_to(8'h00);
      run_to("pwm_duty40", 8'h00, 8'h40);
      wr(8'hC2, 8'h00);
      run_to("pwm_duty40_tail", 8'h00, 8'h40);
      run_to("pwm_duty0", 8'h00, 8'h00);

      // Deferred duty: write mid-period, then write on the wrap edge
      run_to("defer_pre", 8'd100, 8'h00);
      wr(8'hC2, 8'h80);
      run_to("defer_old_duty", 8'h00, 8'h00);
      run_to("defer_duty80", 8'h00, 8'h80);
      run_to("defer_duty80_b", 8'hFF, 8'h80);
      wr(8'hC2, 8'h20);
      run_to("wrap_write_old", 8'h00, 8'h80);
      run_to("wrap_write_new", 8'h00, 8'h20);

      // Blink, RATE=0: low nibble toggles every 4 cycles starting lit
      LED_IN = 16'hA5AF;
      wr(8'hC3, 8'h0F);
      wr(8'hC4, 8'h00);
      wr(8'hC5, 8'h02);
      blink_check("blink_rate0", 16, 4, 16'hA5AF, 16'hA5A0);

      // RATE=2: toggles every 16 cycles
      wr(8'hC5, 8'h0A);
      blink_check("blink_rate2", 64, 16, 16'hA5AF, 16'hA5A0);

      // CTRL write on a tick edge (edge 68 after the previous CTRL write)
      repeat (3) tick();
      wr(8'hC5, 8'h02);
      blink_check("ctrl_tick_collision", 6, 4, 16'hA5AF, 16'hA5A0);

      // Asynchronous reset in the dark phase, between edges
      #2 RESET = 1'b1;
      #1 chk("arst_immediate", 16'h0000);
      @(posedge CLK); #1;
      chk("arst_hold", 16'h0000);
      LED_IN = 16'h3C3C;
      #3 RESET = 1'b0;
      m_pwm = 8'h00;
      tick();
      chk("arst_release", 16'h3C3C);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("arst_pass", 16'h3C3C);
      end

      // Reset values of BRIGHT/BRIGHT_NEXT (full on) and masks (no blanking)
      wr(8'hC5, 8'h01);
      for (int i = 0; i < 300; i++) begin
         tick();
         chk("reset_bright_ff", 16'h3C3C);
      end
      wr(8'hC5, 8'h03);
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("reset_mask_zero", 16'h3C3C);
      end

      // Address decode: neighbouring addresses must not alias into the block
      wr(8'hC0, 8'h0C);
      wr(8'hC1, 8'h0C);
      wr(8'hC6, 8'h0C);
      for (int i = 0; i < 300; i++) begin
         tick();
         chk("addr_decode", 16'h3C3C);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
